mem_arbiter: RTL and testbench

Single-port memory arbiter for the five-stage pipeline. It shares one unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port, with one transaction outstanding at a time. The data port has priority, and IF sees a stall while it waits. The block sits between the pipeline stages and the memory model, and drives the signals that gate PC advance and fetch-valid in IF.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_starve_ctr.sv | 42 ++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: memory command encoding,
// arbiter FSM states and word-address alignment.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_I = 2'b01,
        WAIT_D = 2'b10
    } arb_state_t;

    // Memory is word addressed; byte offset bits are dropped.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation counter for the fetch port. Counts arbitration cycles the fetch
// port loses to the data port while it has a live request, saturating at
// MAX_STARVE; force_o tells the arbiter to grant the fetch port next.
// Only instantiated when ARB_STARVE_EN is defined.
module arb_starve_ctr #(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic force_o
);

    localparam int CW = $clog2(MAX_STARVE + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_STARVE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over increment; saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the IF fetch port and the MEM data port.
// One transaction outstanding at a time; data port has priority.
// Optional build macro ARB_STARVE_EN: after MAX_STARVE consecutive lost
// arbitrations the fetch port is granted even when the data port requests.
//
// state  | meaning
// IDLE   | arbitrate and drive the winner's command; stores complete here
// WAIT_D | data load accepted, waiting for mem_rvalid
// WAIT_I | fetch accepted, waiting for mem_rvalid (may be squashed)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic [1:0]  mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    arb_state_t state_q, state_d;
    logic       squash_q, squash_d;
    logic       force_if;
    logic       if_cand;
    logic       grant_d;
    logic       grant_i;
    logic       rsp_i;
    logic       rsp_d;
    mem_cmd_t   cmd;

    assign if_cand = if_req & ~if_flush;

    // Winner selection; only meaningful in IDLE and never during reset.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if ((state_q == IDLE) && !rst) begin
            grant_d = d_req & ~(force_if & if_cand);
            grant_i = if_cand & ~grant_d;
        end
    end

    // Memory command is driven combinationally from the winning requester.
    always_comb begin
        cmd       = MEM_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            cmd      = d_we ? MEM_STORE : MEM_LOAD;
            mem_addr = word_addr(d_addr);
            if (d_we) begin
                mem_wdata = d_wdata;
            end
        end else if (grant_i) begin
            cmd      = MEM_LOAD;
            mem_addr = word_addr(if_addr);
        end
    end

    assign mem_cmd = cmd;

    assign rsp_d = (state_q == WAIT_D) & mem_rvalid & ~rst;
    assign rsp_i = (state_q == WAIT_I) & mem_rvalid & ~rst;

    assign d_done    = (grant_d & d_we & mem_ready) | rsp_d;
    assign d_rdata   = rsp_d ? mem_rdata : '0;
    assign if_rvalid = rsp_i & ~(squash_q | if_flush);
    assign if_rdata  = rsp_i ? mem_rdata : '0;
    assign if_stall  = if_req & ~if_rvalid;

    // Next-state and squash tracking.
    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        case (state_q)
            IDLE: begin
                squash_d = 1'b0;
                if (mem_ready) begin
                    if (grant_d && !d_we) begin
                        state_d = WAIT_D;
                    end else if (grant_i) begin
                        state_d = WAIT_I;
                    end
                end
            end
            WAIT_I: begin
                squash_d = squash_q | if_flush;
                if (mem_rvalid) begin
                    state_d  = IDLE;
                    squash_d = 1'b0;
                end
            end
            WAIT_D: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                squash_d = 1'b0;
            end
        endcase
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
        end
    end

`ifdef ARB_STARVE_EN
    arb_starve_ctr #(
        .MAX_STARVE(MAX_STARVE)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (grant_d & if_cand),
        .clr_i   ((grant_i & mem_ready) | if_flush),
        .force_o (force_if)
    );
`else
    // Strict data priority; MAX_STARVE has no effect in this build.
    localparam int unused_max_starve = MAX_STARVE;
    assign force_if = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard: expected memory commands,
// fetch responses and data completions are queued as stimulus is issued and a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, d_req, d_we, mem_ready, mem_rvalid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_rvalid, if_stall, d_done;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_cmd;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_exp_t;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
    } d_exp_t;

    cmd_exp_t    cmd_q[$];
    logic [31:0] i_q[$];
    d_exp_t      d_q[$];

    mem_arbiter #(.MAX_STARVE(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w);
        cmd_exp_t e;
        e.cmd = c; e.addr = a; e.wdata = w;
        cmd_q.push_back(e);
    endtask

    task automatic push_d(input bit ld, input logic [31:0] data);
        d_exp_t e;
        e.is_load = ld; e.data = data;
        d_q.push_back(e);
    endtask

    // Monitor: pop and compare every accepted command and every response.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_cmd != MEM_NONE && mem_ready) begin
                n_cmp++;
                if (cmd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL cmd_unexpected: got cmd=%0d addr=%h, expected no command", mem_cmd, mem_addr);
                end else begin
                    cmd_exp_t e;
                    e = cmd_q.pop_front();
                    if (mem_cmd !== e.cmd || mem_addr !== e.addr || mem_wdata !== e.wdata) begin
                        n_err++;
                        $display("FAIL cmd: got cmd=%0d addr=%h wdata=%h, expected cmd=%0d addr=%h wdata=%h",
                                 mem_cmd, mem_addr, mem_wdata, e.cmd, e.addr, e.wdata);
                    end
                end
            end
            if (if_rvalid) begin
                n_cmp++;
                if (i_q.size() == 0) begin
                    n_err++;
                    $display("FAIL if_rvalid_unexpected: got rdata=%h, expected no fetch response", if_rdata);
                end else begin
                    logic [31:0] e;
                    e = i_q.pop_front();
                    if (if_rdata !== e) begin
                        n_err++;
                        $display("FAIL if_rdata: got %h, expected %h", if_rdata, e);
                    end
                end
            end
            if (d_done) begin
                n_cmp++;
                if (d_q.size() == 0) begin
                    n_err++;
                    $display("FAIL d_done_unexpected: got d_done=1 rdata=%h, expected no completion", d_rdata);
                end else begin
                    d_exp_t e;
                    e = d_q.pop_front();
                    if (e.is_load && d_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL d_rdata: got %h, expected %h", d_rdata, e.data);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
        mem_ready = 0; mem_rvalid = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        nxt();

        // Reset: requests and a stray response present, everything quiet.
        d_req = 1; mem_ready = 1; if_req = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("rst_mem_cmd", mem_cmd, MEM_NONE);
        chk("rst_d_done", d_done, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rdata", d_rdata, 0);
        nxt();
        rst = 0; d_req = 0; if_req = 0; mem_ready = 0; mem_rvalid = 0;
        @(negedge clk);
        chk("idle_mem_cmd", mem_cmd, MEM_NONE);
        nxt();

        // Fetch at 0x6, response two cycles later.
        if_req = 1; if_addr = 32'h6; mem_ready = 1;
        push_cmd(MEM_LOAD, 32'h4, 32'h0);
        @(negedge clk); chk("fetch_stall_c0", if_stall, 1);
        nxt(); mem_ready = 0;
        @(negedge clk); chk("fetch_stall_c1", if_stall, 1);
        nxt(); mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; i_q.push_back(32'hDEAD_BEEF);
        @(negedge clk); chk("fetch_rvalid", if_rvalid, 1); chk("fetch_stall_c2", if_stall, 0);
        nxt(); mem_rvalid = 0; if_req = 0;

        // Store and fetch together: store wins, fetch issues next cycle.
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
        if_req = 1; if_addr = 32'h40; mem_ready = 1;
        push_cmd(MEM_STORE, 32'h100, 32'h1234_5678); push_d(0, '0);
        @(negedge clk); chk("store_d_done", d_done, 1); chk("store_if_stall", if_stall, 1);
        nxt(); d_req = 0; d_we = 0;
        push_cmd(MEM_LOAD, 32'h40, 32'h0);
        @(negedge clk); chk("fetch_after_store", mem_cmd, MEM_LOAD);
        nxt(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222; i_q.push_back(32'h1111_2222);
        @(negedge clk);
        nxt(); mem_rvalid = 0; if_req = 0;

        // Flush in the issue cycle suppresses the fetch.
        if_req = 1; if_addr = 32'h60; if_flush = 1; mem_ready = 1;
        @(negedge clk); chk("flush_issue_cmd", mem_cmd, MEM_NONE);
        nxt(); if_req = 0; if_flush = 0;

        // Flush between issue and response drops the response.
        if_req = 1; if_addr = 32'h80; mem_ready = 1;
        push_cmd(MEM_LOAD, 32'h80, 32'h0);
        @(negedge clk);
        nxt(); if_flush = 1; mem_ready = 0;
        nxt(); if_flush = 0; if_req = 0;
        nxt(); mem_rvalid = 1; mem_rdata = 32'hAAAA_5555;
        @(negedge clk); chk("squash_if_rvalid", if_rvalid, 0);
        nxt(); mem_rvalid = 0;
        if_req = 1; if_addr = 32'hC0; mem_ready = 1;
        push_cmd(MEM_LOAD, 32'hC0, 32'h0);
        @(negedge clk); chk("post_squash_issue", mem_cmd, MEM_LOAD);
        nxt(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D; i_q.push_back(32'h0BAD_F00D);
        @(negedge clk); chk("post_squash_rvalid", if_rvalid, 1);
        nxt(); mem_rvalid = 0; if_req = 0;

        // Load held off by mem_ready for three cycles.
        d_req = 1; d_we = 0; d_addr = 32'h203; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_load_cmd", mem_cmd, MEM_LOAD);
            chk("held_load_addr", mem_addr, 32'h200);
            nxt();
        end
        mem_ready = 1; push_cmd(MEM_LOAD, 32'h200, 32'h0);
        @(negedge clk);
        nxt(); mem_ready = 0;
        @(negedge clk); chk("load_wait_done", d_done, 0);
        nxt(); mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D; push_d(1, 32'hCAFE_F00D);
        @(negedge clk); chk("load_done", d_done, 1);
        nxt(); mem_rvalid = 0; d_req = 0;

        // Spurious response in IDLE is ignored.
        mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        @(negedge clk); chk("spurious_d_done", d_done, 0); chk("spurious_if_rvalid", if_rvalid, 0);
        nxt(); mem_rvalid = 0;

        // Back-to-back stores contending with a fetch.
        if_req = 1; if_addr = 32'h500; mem_ready = 1; d_req = 1; d_we = 1;
`ifdef ARB_STARVE_EN
        for (int i = 0; i < 4; i++) begin
            d_addr = 32'h300 + 32'(4 * i); d_wdata = 32'h1000 + 32'(i);
            push_cmd(MEM_STORE, d_addr, d_wdata); push_d(0, '0);
            @(negedge clk); chk("starve_store_done", d_done, 1);
            nxt();
        end
        d_addr = 32'h310; d_wdata = 32'h1004;
        push_cmd(MEM_LOAD, 32'h500, 32'h0);
        @(negedge clk); chk("starve_if_wins_cmd", mem_cmd, MEM_LOAD); chk("starve_if_wins_d", d_done, 0);
        nxt(); mem_rvalid = 1; mem_rdata = 32'h55AA_55AA; i_q.push_back(32'h55AA_55AA);
        @(negedge clk); chk("starve_if_rvalid", if_rvalid, 1);
        nxt(); mem_rvalid = 0; if_req = 0;
        push_cmd(MEM_STORE, 32'h310, 32'h1004); push_d(0, '0);
        @(negedge clk); chk("starve_store_resume", d_done, 1);
        nxt(); d_req = 0; d_we = 0;
`else
        for (int i = 0; i < 6; i++) begin
            d_addr = 32'h300 + 32'(4 * i); d_wdata = 32'h1000 + 32'(i);
            push_cmd(MEM_STORE, d_addr, d_wdata); push_d(0, '0);
            @(negedge clk); chk("prio_store_done", d_done, 1); chk("prio_if_stall", if_stall, 1);
            nxt();
        end
        d_req = 0; d_we = 0;
        push_cmd(MEM_LOAD, 32'h500, 32'h0);
        @(negedge clk); chk("prio_if_issue", mem_cmd, MEM_LOAD);
        nxt(); mem_rvalid = 1; mem_rdata = 32'h55AA_55AA; i_q.push_back(32'h55AA_55AA);
        @(negedge clk);
        nxt(); mem_rvalid = 0; if_req = 0;
`endif

        // Reset while a load is outstanding; late response discarded.
        d_req = 1; d_we = 0; d_addr = 32'h400; mem_ready = 1;
        push_cmd(MEM_LOAD, 32'h400, 32'h0);
        @(negedge clk);
        nxt(); rst = 1; mem_ready = 0;
        @(negedge clk); chk("rst_wait_d_cmd", mem_cmd, MEM_NONE); chk("rst_wait_d_done", d_done, 0);
        nxt(); rst = 0; d_req = 0; mem_rvalid = 1; mem_rdata = 32'h9999_9999;
        @(negedge clk); chk("post_rst_d_done", d_done, 0); chk("post_rst_cmd", mem_cmd, MEM_NONE);
        nxt(); mem_rvalid = 0;
        if_req = 1; if_addr = 32'h600; mem_ready = 1;
        push_cmd(MEM_LOAD, 32'h600, 32'h0);
        @(negedge clk); chk("post_rst_idle_issue", mem_cmd, MEM_LOAD);
        nxt(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1357_9BDF; i_q.push_back(32'h1357_9BDF);
        @(negedge clk);
        nxt(); mem_rvalid = 0; if_req = 0;
        nxt();

        chk("cmd_q_drained", 32'(cmd_q.size()), 0);
        chk("i_q_drained", 32'(i_q.size()), 0);
        chk("d_q_drained", 32'(d_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
